// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared types and segment glyph table for the two-digit SSD scheduler
package ssd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHOW0,
    BLANK0,
    SHOW1,
    BLANK1
  } ssd_state_t;

  // Active-high {g,f,e,d,c,b,a}; the top applies output polarity.
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Index 15 is leftmost: F,E,d,C,b,A,9,8,7,6,5,4,3,2,1,0
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/ssd_hex_decoder.sv
// rtl/ssd_hex_decoder.sv - combinational hex nibble to active-high 7-segment glyph
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/ssd_display_scheduler.sv
// rtl/ssd_display_scheduler.sv - two-digit PmodSSD scan with blanking gaps and frame-aligned value commit
// Optional BLANK_LEADING_ZERO_EN: suppress a zero high digit.
module ssd_display_scheduler
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV  = 50_000,
  parameter int BLANK_CYCLES = 1_000,
  parameter bit SEG_ACT_LOW  = 1'b0
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] value_in,
  input  logic       value_valid,
  output logic       value_ready,
  output logic [6:0] seg_out,
  output logic       digit_sel,
  output logic       frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [6:0] SEG_POL = {7{SEG_ACT_LOW}};

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_cfg
    $error("BLANK_CYCLES must be >= 1 and < REFRESH_DIV");
  end

  ssd_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [7:0]       pending, display, display_d;
  logic             pending_full;
  logic             last_cnt, frame_end, commit, accept;
  logic [3:0]       nibble;
  logic [6:0]       dec_seg, seg_d;
  logic             digit_d;

  ssd_hex_decoder u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    last_cnt = 1'b0;
    case (state)
      SHOW0, SHOW1:   last_cnt = (cnt == SHOW_LAST);
      BLANK0, BLANK1: last_cnt = (cnt == BLANK_LAST);
      default:        last_cnt = 1'b0;
    endcase

    frame_end   = enable && (state == BLANK1) && last_cnt;
    commit      = frame_end && pending_full;
    value_ready = !pending_full || commit;
    accept      = value_valid && value_ready;
    display_d   = commit ? pending : display;

    state_d = state;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:    state_d = SHOW0;
        SHOW0:   if (last_cnt) state_d = BLANK0;
        BLANK0:  if (last_cnt) state_d = SHOW1;
        SHOW1:   if (last_cnt) state_d = BLANK1;
        BLANK1:  if (last_cnt) state_d = SHOW0;
        default: state_d = IDLE;
      endcase
    end

    if (state_d == IDLE || state_d != state) cnt_d = '0;
    else                                     cnt_d = cnt + CNT_W'(1);

    // Outputs are built from the state being entered and the value it will show.
    nibble = (state_d == SHOW1) ? display_d[7:4] : display_d[3:0];
    seg_d  = SEG_BLANK;
    case (state_d)
      SHOW0: seg_d = dec_seg;
`ifdef BLANK_LEADING_ZERO_EN
      SHOW1: seg_d = (display_d[7:4] == 4'h0) ? SEG_BLANK : dec_seg;
`else
      SHOW1: seg_d = dec_seg;
`endif
      default: seg_d = SEG_BLANK;
    endcase
    digit_d = (state_d == SHOW1) || (state_d == BLANK1);
  end

  assign frame_done = frame_end;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      seg_out      <= SEG_BLANK ^ SEG_POL;
      digit_sel    <= 1'b0;
      pending      <= 8'h00;
      pending_full <= 1'b0;
      display      <= 8'h00;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      seg_out      <= seg_d ^ SEG_POL;
      digit_sel    <= digit_d;
      display      <= display_d;
      pending_full <= accept || (pending_full && !commit);
      if (accept) pending <= value_in;
    end
  end

endmodule

// File: tb/tb_ssd_display_scheduler.sv
// tb/tb_ssd_display_scheduler.sv - directed bench for ssd_display_scheduler (REFRESH_DIV=10, BLANK_CYCLES=2)
module tb_ssd_display_scheduler;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] value_in;
  logic       value_valid;
  logic       value_ready, value_ready_al;
  logic [6:0] seg_out, seg_al;
  logic       digit_sel, digit_al;
  logic       frame_done, fd_al;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef BLANK_LEADING_ZERO_EN
  localparam logic [6:0] HI_ZERO = 7'h00;
`else
  localparam logic [6:0] HI_ZERO = 7'h3F;
`endif

  always #5 clk_in = ~clk_in;

  ssd_display_scheduler #(.REFRESH_DIV(10), .BLANK_CYCLES(2), .SEG_ACT_LOW(1'b0)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .enable      (enable),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .seg_out     (seg_out),
    .digit_sel   (digit_sel),
    .frame_done  (frame_done)
  );

  ssd_display_scheduler #(.REFRESH_DIV(10), .BLANK_CYCLES(2), .SEG_ACT_LOW(1'b1)) dut_al (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .enable      (enable),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready_al),
    .seg_out     (seg_al),
    .digit_sel   (digit_al),
    .frame_done  (fd_al)
  );

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [6:0] seg, input logic dig,
                             input logic fd, input logic rdy);
    logic [6:0] seg_inv;
    seg_inv = ~seg;
    chk(tag, {seg_out, digit_sel, frame_done, value_ready, seg_al, digit_al, fd_al, value_ready_al},
             {seg, dig, fd, rdy, seg_inv, dig, fd, rdy});
  endtask

  // Frame cycle i: 0-7 digit0 lit, 8-9 blank, 10-17 digit1 lit, 18-19 blank; frame_done on 19.
  task automatic check_frame(input logic [6:0] lo, input logic [6:0] hi, input int first, input int stop);
    logic [6:0] exp_seg, exp_inv;
    logic       dig, fd;
    for (int i = first; i < stop; i++) begin
      dig     = (i >= 10);
      fd      = (i == 19);
      exp_seg = ((i % 10) < 8) ? (dig ? hi : lo) : 7'h00;
      exp_inv = ~exp_seg;
      chk($sformatf("frame[%0d]", i), {seg_out, digit_sel, frame_done, seg_al, digit_al, fd_al},
          {exp_seg, dig, fd, exp_inv, dig, fd});
      tick();
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    value_in    = 8'h00;
    value_valid = 1'b0;
    tick();
    tick();
    chk_outputs("reset", 7'h00, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    tick();
    chk_outputs("idle_disabled", 7'h00, 1'b0, 1'b0, 1'b1);

    // Free-running scan of the reset value 0x00.
    enable = 1'b1;
    tick();
    check_frame(7'h3F, HI_ZERO, 0, 20);
    check_frame(7'h3F, HI_ZERO, 0, 20);

    // 0xA5 accepted mid-SHOW0 appears only in the following frame.
    check_frame(7'h3F, HI_ZERO, 0, 2);
    value_in    = 8'hA5;
    value_valid = 1'b1;
    chk("a5_ready", value_ready, 1'b1);
    tick();
    value_valid = 1'b0;
    chk("a5_pending", value_ready, 1'b0);
    check_frame(7'h3F, HI_ZERO, 3, 20);
    check_frame(7'h6D, 7'h77, 0, 20);
    chk("a5_committed", value_ready, 1'b1);

    // 0x12 accepted, 0x34 held on valid until the next commit takes it.
    value_in    = 8'h12;
    value_valid = 1'b1;
    chk("12_ready", value_ready, 1'b1);
    tick();
    value_in = 8'h34;
    chk("34_blocked", value_ready, 1'b0);
    check_frame(7'h6D, 7'h77, 1, 20);
    value_valid = 1'b0;
    chk("34_pending", value_ready, 1'b0);
    check_frame(7'h5B, 7'h06, 0, 20);
    chk("34_committed", value_ready, 1'b1);

    // Drop enable mid-SHOW1; a write made while idle must wait for a running frame.
    check_frame(7'h66, 7'h4F, 0, 13);
    enable = 1'b0;
    tick();
    chk_outputs("disable_blank", 7'h00, 1'b0, 1'b0, 1'b1);
    value_in    = 8'h07;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    chk_outputs("idle_write", 7'h00, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk_outputs("idle_hold", 7'h00, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    tick();
    check_frame(7'h66, 7'h4F, 0, 20);
    check_frame(7'h07, HI_ZERO, 0, 20);
    chk("07_committed", value_ready, 1'b1);

    // Asynchronous reset mid-BLANK0 with a value pending.
    value_in    = 8'h5A;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    check_frame(7'h07, HI_ZERO, 1, 9);
    chk("5a_pending", value_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_outputs("async_reset", 7'h00, 1'b0, 1'b0, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    check_frame(7'h3F, HI_ZERO, 0, 20);
    check_frame(7'h3F, HI_ZERO, 0, 20);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
